// File: rtl/stream_frame_receiver.sv
// Captures one MaxAddress-word frame from an nd/lastData stream, validates its length,
// and holds it for a reader through a ready/ack handshake. Optional: FRAME_CHECKSUM_EN.
module stream_frame_receiver #(
    parameter int unsigned MaxAddress = 20,
    parameter int unsigned bitwidth   = 5,
    parameter int unsigned DataWidth  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 nd,
    input  logic                 lastData,
    input  logic [DataWidth-1:0] din,
    input  logic                 frame_ack,
    input  logic [bitwidth-1:0]  rd_addr,
    output logic [DataWidth-1:0] rd_data,
    output logic                 frame_ready,
    output logic                 frame_error,
    output logic                 overrun,
`ifdef FRAME_CHECKSUM_EN
    output logic [DataWidth-1:0] checksum,
`endif
    output logic [bitwidth-1:0]  wr_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    // Full-frame count on bitwidth+1 bits so MaxAddress = 2^bitwidth compares correctly.
    localparam logic [bitwidth:0] MAX_CNT = (bitwidth + 1)'(MaxAddress);

    logic [1:0]           r_state;
    logic [bitwidth-1:0]  r_wr_count;
    logic                 r_frame_ready;
    logic                 r_frame_error;
    logic                 r_overrun;
    logic [DataWidth-1:0] r_rd_data;
    logic [DataWidth-1:0] r_buf [MaxAddress];

    logic [1:0]           w_state_nxt;
    logic [bitwidth-1:0]  w_count_nxt;
    logic                 w_ready_nxt;
    logic                 w_error_nxt;
    logic                 w_overrun_nxt;
    logic                 w_we;
    logic [bitwidth-1:0]  w_waddr;
    logic [bitwidth:0]    w_count_inc;

`ifdef FRAME_CHECKSUM_EN
    logic [DataWidth-1:0] r_checksum;
    logic [DataWidth-1:0] w_checksum_nxt;
`endif

    assign w_count_inc = {1'b0, r_wr_count} + (bitwidth + 1)'(1);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_wr_count;
        w_ready_nxt   = r_frame_ready;
        w_error_nxt   = 1'b0;
        w_overrun_nxt = r_overrun;
        w_we          = 1'b0;
        w_waddr       = r_wr_count;
`ifdef FRAME_CHECKSUM_EN
        w_checksum_nxt = r_checksum;
`endif
        case (r_state)
            ST_IDLE: begin
                if (nd) begin
                    w_we    = 1'b1;
                    w_waddr = '0;
                    if (lastData) begin
                        w_error_nxt = 1'b1;
                        w_count_nxt = '0;
`ifdef FRAME_CHECKSUM_EN
                        w_checksum_nxt = '0;
`endif
                    end else begin
                        w_count_nxt = bitwidth'(1);
                        w_state_nxt = ST_FILL;
`ifdef FRAME_CHECKSUM_EN
                        w_checksum_nxt = din;
`endif
                    end
                end
            end
            ST_FILL: begin
                if (nd) begin
                    w_we = 1'b1;
                    if (lastData && (w_count_inc == MAX_CNT)) begin
                        w_count_nxt = bitwidth'(w_count_inc);
                        w_ready_nxt = 1'b1;
                        w_state_nxt = ST_READY;
`ifdef FRAME_CHECKSUM_EN
                        w_checksum_nxt = r_checksum + din;
`endif
                    end else if (lastData || (w_count_inc == MAX_CNT)) begin
                        // Short or long frame: drop it and wait for a new start word.
                        w_error_nxt = 1'b1;
                        w_count_nxt = '0;
                        w_state_nxt = ST_IDLE;
`ifdef FRAME_CHECKSUM_EN
                        w_checksum_nxt = '0;
`endif
                    end else begin
                        w_count_nxt = bitwidth'(w_count_inc);
`ifdef FRAME_CHECKSUM_EN
                        w_checksum_nxt = r_checksum + din;
`endif
                    end
                end
            end
            ST_READY: begin
                if (nd) begin
                    w_overrun_nxt = 1'b1;
                end
                if (frame_ack) begin
                    w_ready_nxt = 1'b0;
                    w_count_nxt = '0;
                    w_state_nxt = ST_IDLE;
`ifdef FRAME_CHECKSUM_EN
                    w_checksum_nxt = '0;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_wr_count    <= '0;
            r_frame_ready <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
            r_rd_data     <= '0;
`ifdef FRAME_CHECKSUM_EN
            r_checksum    <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_wr_count    <= w_count_nxt;
            r_frame_ready <= w_ready_nxt;
            r_frame_error <= w_error_nxt;
            r_overrun     <= w_overrun_nxt;
            r_rd_data     <= ({1'b0, rd_addr} < MAX_CNT) ? r_buf[rd_addr] : '0;
`ifdef FRAME_CHECKSUM_EN
            r_checksum    <= w_checksum_nxt;
`endif
        end
    end

    // Frame buffer is not reset; a held frame survives until overwritten.
    always_ff @(posedge clock) begin
        if (reset && w_we) begin
            r_buf[w_waddr] <= din;
        end
    end

    assign rd_data     = r_rd_data;
    assign frame_ready = r_frame_ready;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;
    assign wr_count    = r_wr_count;
`ifdef FRAME_CHECKSUM_EN
    assign checksum    = r_checksum;
`endif

endmodule

// File: tb/tb_stream_frame_receiver.sv
// Directed bench for stream_frame_receiver: good, short, long, gapped and overrun frames.
// Honours FRAME_CHECKSUM_EN when defined.
module tb_stream_frame_receiver;

    logic       clock = 1'b0;
    logic       reset;
    logic       nd;
    logic       lastData;
    logic [7:0] din;
    logic       frame_ack;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_ready;
    logic       frame_error;
    logic       overrun;
    logic [4:0] wr_count;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int total = 0;
    int bad   = 0;

    stream_frame_receiver #(.MaxAddress(20), .bitwidth(5), .DataWidth(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .nd          (nd),
        .lastData    (lastData),
        .din         (din),
        .frame_ack   (frame_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ready (frame_ready),
        .frame_error (frame_error),
        .overrun     (overrun),
`ifdef FRAME_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .wr_count    (wr_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        nd       = 1'b1;
        din      = d;
        lastData = last;
        tick();
        nd       = 1'b0;
        lastData = 1'b0;
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
        rd_addr = a;
        tick();
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        reset     = 1'b0;
        nd        = 1'b0;
        lastData  = 1'b0;
        din       = '0;
        frame_ack = 1'b0;
        rd_addr   = '0;

        // Reset held for three cycles
        repeat (3) tick();
        check("rst_ready",   32'(frame_ready), 32'(0));
        check("rst_overrun", 32'(overrun),     32'(0));
        check("rst_count",   32'(wr_count),    32'(0));
        check("rst_error",   32'(frame_error), 32'(0));
        check("rst_rd_data", 32'(rd_data),     32'(0));
        reset = 1'b1;
        tick();
        check("post_rst_error", 32'(frame_error), 32'(0));
        check("post_rst_ready", 32'(frame_ready), 32'(0));

        // Nominal 20-word frame, din = 0..19
        for (int i = 0; i < 20; i++) begin
            send(8'(i), i == 19);
            if (i == 18) begin
                check("nom_count_19", 32'(wr_count),    32'(19));
                check("nom_ready_lo", 32'(frame_ready), 32'(0));
            end
        end
        check("nom_ready",    32'(frame_ready), 32'(1));
        check("nom_count_20", 32'(wr_count),    32'(20));
        check("nom_no_error", 32'(frame_error), 32'(0));
`ifdef FRAME_CHECKSUM_EN
        check("nom_checksum", 32'(checksum), 32'(190));
`endif
        read_chk("nom_rd7",  5'd7,  8'd7);
        read_chk("nom_rd19", 5'd19, 8'd19);
        read_chk("nom_rd0",  5'd0,  8'd0);
        ack();
        check("nom_ack_ready", 32'(frame_ready), 32'(0));
        check("nom_ack_count", 32'(wr_count),    32'(0));

        // Short frame of 5 words; ack mid-fill must be ignored
        send(8'd100, 1'b0);
        send(8'd101, 1'b0);
        ack();
        check("ack_ignored_count", 32'(wr_count), 32'(2));
        send(8'd102, 1'b0);
        send(8'd103, 1'b0);
        send(8'd104, 1'b1);
        check("short_error", 32'(frame_error), 32'(1));
        check("short_count", 32'(wr_count),    32'(0));
        check("short_ready", 32'(frame_ready), 32'(0));
        tick();
        check("short_error_pulse", 32'(frame_error), 32'(0));
        for (int i = 0; i < 20; i++) send(8'(200 + i), i == 19);
        check("after_short_ready", 32'(frame_ready), 32'(1));
        check("after_short_error", 32'(frame_error), 32'(0));
        read_chk("after_short_rd3", 5'd3, 8'd203);
        ack();

        // Long frame: 21 words without lastData
        for (int i = 0; i < 20; i++) send(8'(50 + i), 1'b0);
        check("long_error", 32'(frame_error), 32'(1));
        check("long_count", 32'(wr_count),    32'(0));
        send(8'd70, 1'b0);
        check("long_restart_count", 32'(wr_count),    32'(1));
        check("long_error_pulse",   32'(frame_error), 32'(0));
        for (int i = 1; i < 20; i++) send(8'(70 + i), i == 19);
        check("long_next_ready", 32'(frame_ready), 32'(1));
`ifdef FRAME_CHECKSUM_EN
        check("long_next_checksum", 32'(checksum), 32'(54));
`endif
        read_chk("long_next_rd0",  5'd0,  8'd70);
        read_chk("long_next_rd19", 5'd19, 8'd89);
        ack();

        // Gapped stream: three idle cycles between words
        for (int i = 0; i < 20; i++) begin
            send(8'(i * 3 + 1), i == 19);
            if (i != 19) begin
                repeat (3) tick();
                check("gap_no_ready", 32'(frame_ready), 32'(0));
            end
        end
        check("gap_ready", 32'(frame_ready), 32'(1));
        for (int i = 0; i < 20; i++) read_chk("gap_rd", 5'(i), 8'(i * 3 + 1));

        // Words arriving while the frame is held
        send(8'hEE, 1'b0);
        check("ovr_set",   32'(overrun),     32'(1));
        check("ovr_ready", 32'(frame_ready), 32'(1));
        check("ovr_count", 32'(wr_count),    32'(20));
        send(8'hEF, 1'b1);
        check("ovr_sticky", 32'(overrun), 32'(1));
        nd        = 1'b1;
        din       = 8'hDD;
        frame_ack = 1'b1;
        tick();
        nd        = 1'b0;
        frame_ack = 1'b0;
        check("ovr_ack_ready",   32'(frame_ready), 32'(0));
        check("ovr_ack_overrun", 32'(overrun),     32'(1));
        check("ovr_ack_count",   32'(wr_count),    32'(0));
        read_chk("ovr_buf_rd0", 5'd0, 8'd1);
        read_chk("ovr_buf_rd5", 5'd5, 8'd16);
        for (int i = 0; i < 20; i++) send(8'(i + 10), i == 19);
        check("ovr_next_ready",   32'(frame_ready), 32'(1));
        check("ovr_next_overrun", 32'(overrun),     32'(1));
        read_chk("ovr_next_rd2", 5'd2, 8'd12);

        // Reset mid-hold clears flags
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rst2_overrun", 32'(overrun),     32'(0));
        check("rst2_ready",   32'(frame_ready), 32'(0));
        check("rst2_count",   32'(wr_count),    32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
